// File: rtl/int8_32x32_stream_driver.sv
// Host-side feeder for the 32x32 int8 matmul stream wrapper: buffers A/B, streams them, collects C.
// Define DRV_TIMEOUT_EN to add the stall watchdog and ERR state.
module int8_32x32_stream_driver #(
  parameter int unsigned ROWS           = 32,
  parameter int unsigned IN_W           = 256,
  parameter int unsigned OUT_W          = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic             ap_continue,
  input  logic             ld_we,
  input  logic             ld_sel,
  input  logic [4:0]       ld_addr,
  input  logic [IN_W-1:0]  ld_data,
  input  logic [4:0]       rd_addr,
  output logic [OUT_W-1:0] rd_data,
  output logic             mm_start,
  input  logic             mm_idle,
  input  logic             mm_done,
  output logic             mm_continue,
  output logic [IN_W-1:0]  a_tdata,
  output logic             a_tvalid,
  input  logic             a_tready,
  output logic [IN_W-1:0]  b_tdata,
  output logic             b_tvalid,
  input  logic             b_tready,
  input  logic [OUT_W-1:0] c_tdata,
  input  logic             c_tvalid,
  output logic             c_tready,
  output logic             err
);

  localparam logic [4:0] LAST = 5'(ROWS - 1);

`ifdef DRV_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE, KICK, SEND_A, SEND_B, RECV_C, WAIT_DONE, FINISH, ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, KICK, SEND_A, SEND_B, RECV_C, WAIT_DONE, FINISH
  } state_t;
`endif

  state_t           state_q;
  logic [4:0]       cnt_q;
  logic [4:0]       cnt_nx;
  logic             mm_start_q;
  logic             mm_cont_q;
  logic             done_q;
  logic             pend_q;
  logic             a_vld_q;
  logic             b_vld_q;
  logic             c_rdy_q;
  logic [IN_W-1:0]  a_dat_q;
  logic [IN_W-1:0]  b_dat_q;
  logic [OUT_W-1:0] rd_q;

  logic [IN_W-1:0]  a_mem [ROWS];
  logic [IN_W-1:0]  b_mem [ROWS];
  logic [OUT_W-1:0] c_mem [ROWS];

  logic ld_a;
  logic ld_b;
  logic a_fire;
  logic b_fire;
  logic c_fire;

  assign ld_a   = ld_we & ~ld_sel & (state_q == IDLE);
  assign ld_b   = ld_we &  ld_sel & (state_q == IDLE);
  assign a_fire = a_vld_q & a_tready;
  assign b_fire = b_vld_q & b_tready;
  assign c_fire = c_rdy_q & c_tvalid;
  assign cnt_nx = cnt_q + 5'd1;

  assign ap_idle     = (state_q == IDLE);
  assign ap_ready    = (state_q == IDLE);
  assign ap_done     = done_q;
  assign mm_start    = mm_start_q;
  assign mm_continue = mm_cont_q;
  assign a_tvalid    = a_vld_q;
  assign a_tdata     = a_dat_q;
  assign b_tvalid    = b_vld_q;
  assign b_tdata     = b_dat_q;
  assign c_tready    = c_rdy_q;
  assign rd_data     = rd_q;

  // Buffer storage keeps its contents across reset.
  always_ff @(posedge ap_clk) begin
    if (ld_a)   a_mem[ld_addr] <= ld_data;
    if (ld_b)   b_mem[ld_addr] <= ld_data;
    if (c_fire) c_mem[cnt_q]   <= c_tdata;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rd_q <= '0;
    else           rd_q <= c_mem[rd_addr];
  end

`ifdef DRV_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stall_q;
  logic          err_q;
  logic          active;
  logic          progress;
  logic          expire;

  assign active   = state_q inside {KICK, SEND_A, SEND_B, RECV_C, WAIT_DONE};
  // Every state exit out of an active state coincides with one of these.
  assign progress = a_fire | b_fire | c_fire
                  | ((state_q == KICK) & ~mm_idle)
                  | ((state_q == WAIT_DONE) & (mm_done | pend_q));
  assign expire   = active & ~progress
                  & (stall_q == SW'(TIMEOUT_CYCLES - 1));
  assign err      = err_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)               stall_q <= '0;
    else if (active & ~progress) stall_q <= stall_q + 1'b1;
    else                         stall_q <= '0;
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mm_start_q <= 1'b0;
      mm_cont_q  <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      a_vld_q    <= 1'b0;
      b_vld_q    <= 1'b0;
      c_rdy_q    <= 1'b0;
      a_dat_q    <= '0;
      b_dat_q    <= '0;
`ifdef DRV_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      mm_cont_q <= 1'b0;
      // An early wrapper done is remembered until C is fully drained.
      if (mm_done && (state_q inside {SEND_A, SEND_B, RECV_C}))
        pend_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (ap_start) begin
            state_q    <= KICK;
            mm_start_q <= 1'b1;
            pend_q     <= 1'b0;
          end
        end
        KICK: begin
          if (!mm_idle) begin
            state_q    <= SEND_A;
            mm_start_q <= 1'b0;
            cnt_q      <= '0;
            a_vld_q    <= 1'b1;
            a_dat_q    <= a_mem[5'd0];
          end
        end
        SEND_A: begin
          if (a_fire) begin
            if (cnt_q == LAST) begin
              state_q <= SEND_B;
              a_vld_q <= 1'b0;
              cnt_q   <= '0;
              b_vld_q <= 1'b1;
              b_dat_q <= b_mem[5'd0];
            end else begin
              cnt_q   <= cnt_nx;
              a_dat_q <= a_mem[cnt_nx];
            end
          end
        end
        SEND_B: begin
          if (b_fire) begin
            if (cnt_q == LAST) begin
              state_q <= RECV_C;
              b_vld_q <= 1'b0;
              cnt_q   <= '0;
              c_rdy_q <= 1'b1;
            end else begin
              cnt_q   <= cnt_nx;
              b_dat_q <= b_mem[cnt_nx];
            end
          end
        end
        RECV_C: begin
          if (c_fire) begin
            if (cnt_q == LAST) begin
              state_q <= WAIT_DONE;
              c_rdy_q <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_nx;
            end
          end
        end
        WAIT_DONE: begin
          if (mm_done || pend_q) begin
            state_q   <= FINISH;
            mm_cont_q <= 1'b1;
            pend_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        FINISH: begin
          if (ap_continue) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
`ifdef DRV_TIMEOUT_EN
        ERR: begin
          if (ap_continue) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
`ifdef DRV_TIMEOUT_EN
      if (expire) begin
        state_q    <= ERR;
        a_vld_q    <= 1'b0;
        b_vld_q    <= 1'b0;
        c_rdy_q    <= 1'b0;
        mm_start_q <= 1'b0;
        mm_cont_q  <= 1'b0;
        pend_q     <= 1'b0;
        cnt_q      <= '0;
        err_q      <= 1'b1;
        done_q     <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_int8_32x32_stream_driver.sv
// Scoreboard bench for int8_32x32_stream_driver with a behavioural wrapper model.
`timescale 1ns/1ps
module tb_int8_32x32_stream_driver;

  localparam int ROWS  = 32;
  localparam int IN_W  = 256;
  localparam int OUT_W = 512;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             ap_start = 1'b0;
  logic             ap_done, ap_idle, ap_ready;
  logic             ap_continue = 1'b0;
  logic             ld_we = 1'b0;
  logic             ld_sel = 1'b0;
  logic [4:0]       ld_addr = '0;
  logic [IN_W-1:0]  ld_data = '0;
  logic [4:0]       rd_addr = '0;
  logic [OUT_W-1:0] rd_data;
  logic             mm_start;
  logic             mm_idle;
  logic             mm_done;
  logic             mm_continue;
  logic [IN_W-1:0]  a_tdata;
  logic             a_tvalid;
  logic             a_tready;
  logic [IN_W-1:0]  b_tdata;
  logic             b_tvalid;
  logic             b_tready;
  logic [OUT_W-1:0] c_tdata;
  logic             c_tvalid;
  logic             c_tready;
  logic             err;

  int_unused_guard u_dummy_never ();

  int8_32x32_stream_driver dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .ap_continue(ap_continue), .ld_we(ld_we), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .mm_start(mm_start), .mm_idle(mm_idle),
    .mm_done(mm_done), .mm_continue(mm_continue),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready),
    .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tready(c_tready),
    .err(err)
  );

  always #5 ap_clk = ~ap_clk;

  logic [IN_W-1:0]  exp_a[$];
  logic [IN_W-1:0]  exp_b[$];
  logic [OUT_W-1:0] exp_rd[$];
  int n_chk = 0;
  int n_err = 0;
  int a_hs = 0;
  int b_hs = 0;
  int mc_cnt = 0;
  int a_mode = 0;
  int b_mode = 0;
  bit rd_chk = 1'b0;

  function automatic logic [IN_W-1:0] a_ref(int r);
    logic [7:0] v;
    v = 8'(r);
    return {32{v}};
  endfunction

  function automatic logic [IN_W-1:0] b_ref(int c);
    logic [7:0] v;
    v = 8'hC0 + 8'(c);
    return {32{v}};
  endfunction

  function automatic logic [OUT_W-1:0] c_ref(int k);
    logic [15:0] v;
    v = 16'h0100 + 16'(k);
    return {16{v}};
  endfunction

  task automatic check(string nm, logic [OUT_W-1:0] act,
                       logic [OUT_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Ready patterns: 0 always high, 1 toggling, 2 held low.
  initial begin
    a_tready = 1'b0;
    b_tready = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1;
      case (a_mode)
        0:       a_tready = 1'b1;
        1:       a_tready = ~a_tready;
        default: a_tready = 1'b0;
      endcase
      case (b_mode)
        0:       b_tready = 1'b1;
        1:       b_tready = ~b_tready;
        default: b_tready = 1'b0;
      endcase
    end
  end

  // Wrapper model: raises busy on mm_start, eats 32 B beats,
  // returns 32 C rows with gaps, raises done before the last row.
  initial begin
    int wst, k, bcnt, cyc;
    bit fire, bfire, st, cont, idl;
    wst = 0; k = 0; bcnt = 0; cyc = 0;
    mm_idle = 1'b1;
    mm_done = 1'b0;
    c_tvalid = 1'b0;
    c_tdata = '0;
    forever begin
      @(negedge ap_clk);
      fire  = c_tvalid && c_tready;
      bfire = b_tvalid && b_tready;
      st    = mm_start;
      cont  = mm_continue;
      idl   = ap_idle;
      @(posedge ap_clk);
      #1;
      cyc++;
      if (wst != 0 && idl) begin
        wst = 0;
        mm_idle = 1'b1;
        mm_done = 1'b0;
        c_tvalid = 1'b0;
      end else begin
        case (wst)
          0: if (st) begin
            mm_idle = 1'b0;
            bcnt = 0;
            wst = 1;
          end
          1: begin
            if (bfire) bcnt++;
            if (bcnt == ROWS) begin
              k = 0;
              wst = 2;
            end
          end
          2: begin
            if (fire) k++;
            if (k == ROWS) begin
              c_tvalid = 1'b0;
              wst = 3;
            end else if (!c_tvalid || fire) begin
              c_tvalid = (cyc % 3 != 0);
              c_tdata = c_ref(k);
            end
            if (k == ROWS - 1 && c_tvalid) mm_done = 1'b1;
          end
          default: if (cont) begin
            mm_done = 1'b0;
            mm_idle = 1'b1;
            wst = 0;
          end
        endcase
      end
    end
  end

  // Monitor: pops expected beats/reads whenever the DUT presents them.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        if (a_tvalid) begin
          if (exp_a.size() == 0) fail_now("a_extra_beat");
          else if (a_tready) begin
            check("a_beat", a_tdata, exp_a.pop_front());
            a_hs++;
          end else check("a_stall_hold", a_tdata, exp_a[0]);
        end
        if (b_tvalid) begin
          if (exp_b.size() == 0) fail_now("b_extra_beat");
          else if (b_tready) begin
            check("b_beat", b_tdata, exp_b.pop_front());
            b_hs++;
          end else check("b_stall_hold", b_tdata, exp_b[0]);
        end
        if (mm_continue) mc_cnt++;
        if (rd_chk) begin
          if (exp_rd.size() == 0) fail_now("rd_unexpected");
          else check("rd_data", rd_data, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic load(bit sel, int addr, logic [IN_W-1:0] d);
    ld_we = 1'b1;
    ld_sel = sel;
    ld_addr = 5'(addr);
    ld_data = d;
    @(posedge ap_clk);
    #1;
    ld_we = 1'b0;
  endtask

  task automatic rd(int addr, int k);
    @(posedge ap_clk);
    #1;
    rd_addr = 5'(addr);
    exp_rd.push_back(c_ref(k));
    @(posedge ap_clk);
    #1;
    rd_chk = 1'b1;
    @(posedge ap_clk);
    #1;
    rd_chk = 1'b0;
  endtask

  task automatic kick();
    for (int r = 0; r < ROWS; r++) begin
      exp_a.push_back(a_ref(r));
      exp_b.push_back(b_ref(r));
    end
    a_hs = 0;
    b_hs = 0;
    mc_cnt = 0;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    @(negedge ap_clk);
    check("mm_start_rise", mm_start, 1);
    check("idle_low_busy", ap_idle, 0);
    @(negedge ap_clk);
    check("mm_start_hold", mm_start, 1);
    @(negedge ap_clk);
    check("mm_start_drop", mm_start, 0);
    check("a_tvalid_on", a_tvalid, 1);
  endtask

  task automatic finish_txn();
    int t;
    t = 0;
    while (ap_done !== 1'b1 && t < 3000) begin
      @(negedge ap_clk);
      t++;
    end
    if (ap_done !== 1'b1) fail_now("ap_done_wait");
    else begin
      for (int i = 0; i < 5; i++) begin
        check("ap_done_hold", ap_done, 1);
        @(negedge ap_clk);
      end
      check("idle_low_done", ap_idle, 0);
      @(posedge ap_clk);
      #1;
      ap_continue = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_continue = 1'b0;
      @(negedge ap_clk);
      check("idle_after_cont", ap_idle, 1);
      check("done_after_cont", ap_done, 0);
      check("a_hs_count", 32'(a_hs), ROWS);
      check("b_hs_count", 32'(b_hs), ROWS);
      check("mm_cont_pulse", 32'(mc_cnt), 1);
      check("a_queue_empty", 32'(exp_a.size()), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_idle", ap_idle, 1);
    check("rst_ready", ap_ready, 1);
    check("rst_done", ap_done, 0);
    check("rst_a_tvalid", a_tvalid, 0);
    check("rst_b_tvalid", b_tvalid, 0);
    check("rst_c_tready", c_tready, 0);
    check("rst_mm_start", mm_start, 0);
    check("rst_mm_cont", mm_continue, 0);
    check("rst_err", err, 0);
    check("rst_a_tdata", a_tdata, 0);
    check("rst_b_tdata", b_tdata, 0);
    check("rst_rd_data", rd_data, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    for (int r = 0; r < ROWS; r++) begin
      load(1'b0, r, a_ref(r));
      load(1'b1, r, b_ref(r));
    end

    // Full-rate transaction.
    a_mode = 0;
    b_mode = 0;
    kick();
    finish_txn();
    rd(5, 5);
    rd(0, 0);
    rd(31, 31);

    // Toggling ready; loads during the transaction must be ignored.
    a_mode = 1;
    b_mode = 1;
    kick();
    load(1'b0, 0, '1);
    load(1'b1, 3, '0);
    finish_txn();
    rd(17, 17);

    // Reset in the middle of the B stream.
    a_mode = 0;
    b_mode = 0;
    kick();
    t = 0;
    while (b_hs < 10 && t < 500) begin
      @(negedge ap_clk);
      t++;
    end
    if (b_hs < 10) fail_now("b_beat10_wait");
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_b_tvalid", b_tvalid, 0);
    check("mid_rst_b_tdata", b_tdata, 0);
    check("mid_rst_c_tready", c_tready, 0);
    check("mid_rst_idle", ap_idle, 1);
    check("mid_rst_rd_data", rd_data, 0);
    exp_a.delete();
    exp_b.delete();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    rd(7, 7);

    // Resend after reset starts from A[0] with intact buffers.
    kick();
    finish_txn();
    rd(5, 5);
    rd(30, 30);

`ifdef DRV_TIMEOUT_EN
    b_mode = 2;
    kick();
    t = 0;
    while (err !== 1'b1 && t < 1500) begin
      @(negedge ap_clk);
      t++;
    end
    if (err !== 1'b1) fail_now("err_wait");
    check("to_err", err, 1);
    check("to_done", ap_done, 1);
    check("to_b_tvalid", b_tvalid, 0);
    exp_b.delete();
    @(posedge ap_clk);
    #1;
    ap_continue = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_continue = 1'b0;
    b_mode = 0;
    @(negedge ap_clk);
    check("to_err_clear", err, 0);
    check("to_idle", ap_idle, 1);
`endif

    repeat (3) @(posedge ap_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

module int_unused_guard;
endmodule

// File: doc/int8_32x32_stream_driver.md
Name: int8_32x32_stream_driver

Overview:
Initiator-side companion to the 32x32 int8 matmul stream wrapper. It holds matrix A (32 rows × 256 bit) and matrix B (32 columns × 256 bit) in local buffers, loaded through a simple write port. On start it kicks the wrapper, transmits A then B over AXI-Stream, and collects the 32 result rows (512 bit each) into a readable result buffer. It then completes the wrapper's ap_ctrl handshake. Used as the test/host-side driver and as the feeder in tiled accelerator builds.

Parameters:
ROWS, 32, beats per matrix (A rows, B cols, C rows)
IN_W, 256, A/B beat width in bits
OUT_W, 512, C beat width in bits
TIMEOUT_CYCLES, 1024, stall limit for the optional watchdog

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  start a full transaction
ap_done  out  1  transaction complete; held until ap_continue
ap_idle  out  1  high in IDLE
ap_ready  out  1  high in IDLE
ap_continue  in  1  acknowledge done
ld_we  in  1  buffer write strobe
ld_sel  in  1  0 = A buffer, 1 = B buffer
ld_addr  in  5  row/column index
ld_data  in  IN_W  write data
rd_addr  in  5  result row index
rd_data  out  OUT_W  result row; registered read, 1-cycle latency
mm_start  out  1  wrapper ap_start
mm_idle  in  1  wrapper ap_idle
mm_done  in  1  wrapper ap_done
mm_continue  out  1  wrapper ap_continue
a_tdata  out  IN_W  A stream data
a_tvalid  out  1  A stream valid
a_tready  in  1  A stream ready
b_tdata  out  IN_W  B stream data
b_tvalid  out  1  B stream valid
b_tready  in  1  B stream ready
c_tdata  in  OUT_W  C stream data
c_tvalid  in  1  C stream valid
c_tready  out  1  C stream ready
err  out  1  watchdog fired (tied 0 when the feature is absent)

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE; beat counter = 0.
  - All of these are 0: a_tvalid, b_tvalid, c_tready, mm_start, mm_continue, ap_done, err, a_tdata, b_tdata, rd_data.
  - ap_idle = ap_ready = 1.
  - Buffer contents are not reset.
- ld_we is honoured only in IDLE; it is ignored in every other state.
- State machine:
  - IDLE: on ap_start, go to KICK.
  - KICK: mm_start = 1. When mm_idle = 0 is sampled, drop mm_start and go to SEND_A with counter = 0.
  - SEND_A: a_tvalid = 1 and a_tdata = A[counter], both registered.
    - On a_tvalid && a_tready: counter++ and the next row is presented on the following cycle, so back-to-back beats are allowed.
    - While stalled, a_tdata stays stable.
    - After beat ROWS-1 handshakes: a_tvalid = 0 next cycle, counter = 0, go to SEND_B.
  - SEND_B: same rules as SEND_A on the b_* signals, using B[counter]. After the last beat, go to RECV_C with counter = 0.
  - RECV_C: c_tready = 1.
    - On c_tvalid && c_tready: C[counter] <= c_tdata, counter++.
    - After beat ROWS-1: c_tready = 0, go to WAIT_DONE.
  - WAIT_DONE: when mm_done = 1, pulse mm_continue for exactly 1 cycle and go to FINISH.
  - FINISH: ap_done = 1. On ap_continue, go to IDLE.
- ap_start is ignored outside IDLE.
- Counters are 5 bits; wrap at 31 → 0 is the exit condition.
- rd_addr may be read in any state. Rows not yet written in the current transaction return stale data.
- If mm_done arrives before all C beats are received, it is held pending and acted on in WAIT_DONE.

Optional Feature:
- Macro: DRV_TIMEOUT_EN.
- Defined:
  - A stall counter resets on every handshake and on every state change. It increments while in KICK, SEND_A, SEND_B, RECV_C or WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: go to ERR. All valids/readies and mm_start are forced to 0; err = 1 and ap_done = 1.
  - ap_continue from ERR returns to IDLE and clears err.
- Undefined: no stall counter and no ERR state; err is tied to 0.

Test Plan:
- Load A[r] = {32{r[7:0]}}, B[c] = {32{8'hC0+c}}; pulse ap_start with a_tready = b_tready = 1 → mm_start holds until mm_idle falls, then 32 consecutive A beats in order 0..31, then 32 B beats.
- a_tready toggling 1,0,1,0 → a_tdata unchanged across every stalled cycle; exactly 32 handshakes; beat k carries A[k].
- Wrapper model emits C row k = {16{16'h0100+k}} with c_tvalid gaps → after ap_done, rd_addr = 5 returns {16{16'h0105}} one cycle later.
- ap_continue delayed 5 cycles after ap_done → ap_done stays high all 5 cycles; mm_continue is a single-cycle pulse; ap_idle returns 1 the cycle after ap_continue.
- ap_rst_n asserted during SEND_B at beat 10 → outputs reset immediately; the next ap_start resends from A[0], and buffer contents are intact.
- With DRV_TIMEOUT_EN: hold b_tready = 0 for 1024 cycles in SEND_B → err = 1, ap_done = 1, b_tvalid = 0; ap_continue clears err and returns to IDLE.
